// File: rtl/arb_wrr_sched.sv
// Weighted round-robin arbiter with lock and park; all outputs come from state registered on the
// clock edge after the inputs are sampled (1-cycle latency); requesters wait, there is no backpressure.
module arb_wrr_sched #(
  parameter int n          = 4,
  parameter int w_width    = 3,
  parameter int park_mode  = 1,
  parameter int park_index = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_n,
  input  logic                   enable,
  input  logic [n-1:0]           request,
  input  logic [w_width*n-1:0]   weight,
  input  logic [n-1:0]           lock,
  input  logic [n-1:0]           mask,
  output logic                   parked,
  output logic                   granted,
  output logic                   locked,
  output logic [n-1:0]           grant,
  output logic [$clog2(n)-1:0]   grant_index
);

  localparam int iw = $clog2(n);

  typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;

  state_t             state, nxt_state;
  logic [iw-1:0]      last, nxt_last, win;
  logic [w_width-1:0] cnt, nxt_cnt, win_w;
  logic [n-1:0]       elig;
  logic               found;
  logic               hold_lock;
  logic               rearb;

  assign elig      = request & ~mask;
  assign hold_lock = lock[last] & request[last];

  // Round-robin search starts just after the last grantee, so the grantee itself is tried last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    win_w = '0;
    for (int k = 1; k <= n; k++) begin
      if (!found && elig[(int'(last) + k) % n]) begin
        found = 1'b1;
        win   = iw'((int'(last) + k) % n);
      end
    end
    for (int i = 0; i < n; i++) begin
      if (win == iw'(i)) win_w = weight[i*w_width +: w_width];
    end
    if (win_w == '0) win_w = w_width'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= iw'(n - 1);
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      last  <= nxt_last;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_last  = last;
    rearb     = 1'b0;
    if (!init_n) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_last  = iw'(n - 1);
    end else if (!enable) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
    end else begin
      case (state)
        IDLE:  rearb = 1'b1;
        GRANT: begin
          if (hold_lock)                    nxt_state = LOCK;
          else if (!elig[last])             rearb = 1'b1;
          else if (cnt <= w_width'(1))      rearb = 1'b1;
          else                              nxt_cnt = cnt - w_width'(1);
        end
        LOCK:  if (!hold_lock) rearb = 1'b1;
        default: nxt_state = IDLE;
      endcase
      if (rearb) begin
        if (found) begin
          nxt_state = GRANT;
          nxt_last  = win;
          nxt_cnt   = win_w;
        end else begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
      end
    end
  end

  always_comb begin
    grant       = '0;
    grant_index = '0;
    parked      = 1'b0;
    granted     = 1'b0;
    locked      = 1'b0;
    if (state != IDLE) begin
      grant[last] = 1'b1;
      grant_index = last;
      granted     = 1'b1;
      locked      = (state == LOCK);
    end else if (park_mode == 1) begin
      grant[park_index] = 1'b1;
      grant_index       = iw'(park_index);
      parked            = 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_wrr_sched.sv
// Bench for arb_wrr_sched: directed scenarios plus random traffic against a burst-accounting model.
module tb_arb_wrr_sched;

  localparam int N = 4;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst_n, init_n, enable;
  logic [N-1:0]   request, lock, mask;
  logic [W*N-1:0] weight;
  logic           parked, granted, locked;
  logic [N-1:0]   grant;
  logic [1:0]     grant_index;

  int passed = 0;
  int total  = 0;

  // Model: owner, whether a grant is active/locked, and cycles left in the current burst.
  bit m_act, m_lck;
  int m_last, m_left;

  arb_wrr_sched #(.n(N), .w_width(W), .park_mode(1), .park_index(0)) dut (
    .clk(clk), .rst_n(rst_n), .init_n(init_n), .enable(enable),
    .request(request), .weight(weight), .lock(lock), .mask(mask),
    .parked(parked), .granted(granted), .locked(locked),
    .grant(grant), .grant_index(grant_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int effw(input int i);
    int v;
    v = int'(weight[i*W +: W]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic void m_reset();
    m_act = 1'b0; m_lck = 1'b0; m_last = N - 1; m_left = 0;
  endfunction

  function automatic void m_pick();
    m_act = 1'b0; m_lck = 1'b0; m_left = 0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (request[idx] && !mask[idx]) begin
        m_act = 1'b1; m_last = idx; m_left = effw(idx);
        return;
      end
    end
  endfunction

  function automatic void m_step();
    bit keep;
    keep = lock[m_last] && request[m_last];
    if (!init_n) m_reset();
    else if (!enable) begin m_act = 1'b0; m_lck = 1'b0; m_left = 0; end
    else if (!m_act) m_pick();
    else if (m_lck) begin if (!keep) m_pick(); end
    else if (keep) m_lck = 1'b1;
    else begin
      m_left--;
      if (!(request[m_last] && !mask[m_last]) || m_left == 0) m_pick();
    end
  endfunction

  task automatic cyc();
    logic [N-1:0] one, eg;
    one = 1;
    @(posedge clk);
    m_step();
    #1;
    eg = m_act ? (one << m_last) : one;
    chk("grant", 32'(grant), 32'(eg));
    chk("grant_index", 32'(grant_index), m_act ? 32'(m_last) : 32'd0);
    chk("parked", 32'(parked), 32'(!m_act));
    chk("granted", 32'(granted), 32'(m_act));
    chk("locked", 32'(locked), 32'(m_act && m_lck));
  endtask

  task automatic do_init();
    init_n = 1'b0;
    cyc();
    init_n = 1'b1;
  endtask

  initial begin
    logic [3:0] seq [7];
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
    rst_n = 1'b0; init_n = 1'b1; enable = 1'b0;
    request = '0; lock = '0; mask = '0; weight = '0;
    m_reset();
    #3;
    chk("rst_grant", 32'(grant), 32'd1);
    chk("rst_index", 32'(grant_index), 32'd0);
    chk("rst_parked", 32'(parked), 32'd1);
    chk("rst_granted", 32'(granted), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Weighted round robin: weights 3,2,1,1 for indices 0..3.
    enable = 1'b1; request = 4'b1111; weight = 12'b001_001_010_011;
    for (int i = 0; i < 14; i++) begin
      cyc();
      chk("wrr_seq", 32'(grant), 32'(seq[i % 7]));
    end

    // Asynchronous reset in the middle of requester 1's burst.
    repeat (4) cyc();
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_grant", 32'(grant), 32'd1);
    chk("arst_granted", 32'(granted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("arst_fresh_idx0", 32'(grant), 32'd1);

    // Lock holds requester 0 despite weight 1 and competition.
    do_init();
    chk("init_parked", 32'(parked), 32'd1);
    weight = 12'b001_001_010_001; lock = 4'b0001;
    cyc();
    chk("lock_first", 32'(grant), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("lock_hold_grant", 32'(grant), 32'd1);
      chk("lock_hold_locked", 32'(locked), 32'd1);
    end
    lock = 4'b0000;
    cyc();
    chk("lock_release", 32'(grant), 32'b0010);
    chk("lock_release_locked", 32'(locked), 32'd0);

    // Mask and drop.
    do_init();
    request = 4'b0110; mask = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("mask_grant", 32'(grant), 32'b0100);
    end
    request = 4'b0010;
    cyc();
    chk("drop_grant", 32'(grant), 32'd1);
    chk("drop_parked", 32'(parked), 32'd1);
    chk("drop_granted", 32'(granted), 32'd0);

    // Enable and init.
    mask = '0;
    do_init();
    request = 4'b1111; weight = 12'b001_001_010_011;
    cyc();
    chk("en_burst", 32'(grant), 32'd1);
    enable = 1'b0;
    cyc();
    chk("en_off_parked", 32'(parked), 32'd1);
    chk("en_off_granted", 32'(granted), 32'd0);
    enable = 1'b1;
    cyc();
    chk("en_resume_next", 32'(grant), 32'b0010);
    init_n = 1'b0;
    cyc();
    chk("init_parked2", 32'(parked), 32'd1);
    chk("init_grant", 32'(grant), 32'd1);
    init_n = 1'b1;
    cyc();
    chk("init_restart0", 32'(grant), 32'd1);
    chk("init_restart_granted", 32'(granted), 32'd1);

    // Sole requester with weight 2 is re-granted without a gap.
    do_init();
    request = 4'b1000; weight = 12'b010_000_000_000;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("sole_grant", 32'(grant), 32'b1000);
      chk("sole_granted", 32'(granted), 32'd1);
    end

    // Random traffic with sticky requests and locks.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) request = 4'($urandom);
      mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 4) == 0) lock = 4'($urandom);
      if ($urandom_range(0, 9) == 0) weight = 12'($urandom);
      enable = ($urandom_range(0, 19) != 0);
      init_n = ($urandom_range(0, 49) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arb_wrr_sched.md
ARB_WRR_SCHED -- requirements
Module: arb_wrr_sched

Interface
REQ-001 SHALL have parameter n, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter w_width, default 3, width of each per-requester weight field.
REQ-003 SHALL have parameter park_mode, default 1: 1 = park on park_index when idle, 0 = no grant when idle.
REQ-004 SHALL have parameter park_index, default 0, parking requester index (0..n-1).
REQ-005 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port init_n, input, 1, synchronous active-low init to reset state.
REQ-008 SHALL have port enable, input, 1, arbitration enable.
REQ-009 SHALL have port request, input, n, request per requester.
REQ-010 SHALL have port weight, input, w_width*n, burst weight; field i = bits [i*w_width +: w_width].
REQ-011 SHALL have port lock, input, n, lock request per requester.
REQ-012 SHALL have port mask, input, n, 1 = requester masked (ineligible).
REQ-013 SHALL have ports parked, granted, locked, output, 1 each, status flags.
REQ-014 SHALL have port grant, output, n, one-hot (or zero) grant vector.
REQ-015 SHALL have port grant_index, output, ceil(log2(n)), binary index of grant.

Function
REQ-016 SHALL register all outputs; decision from inputs sampled at edge t is visible after edge t+1 (1-cycle latency).
REQ-017 SHALL implement states IDLE, GRANT, LOCK; grant shows IDLE as park/zero, GRANT/LOCK as one-hot grantee.
REQ-018 SHALL treat requester i eligible when request[i]=1 and mask[i]=0.
REQ-019 SHALL search round-robin from (last_grantee+1) mod n, wrapping, choosing first eligible index; last_grantee = n-1 after reset/init.
REQ-020 SHALL, on new grant to i, load burst counter with eff_w(i) = weight[i] (0 treated as 1) and enter GRANT.
REQ-021 SHALL, in GRANT, decrement counter each cycle while grantee remains eligible; hold grant until counter reaches terminal (eff_w cycles total).
REQ-022 SHALL, at burst end, rearbitrate from grantee+1; if grantee is sole eligible requester it is re-granted with counter reloaded, no gap cycle.
REQ-023 SHALL, when grantee drops request or becomes masked in GRANT, rearbitrate at that edge (no dead cycle if another is eligible), else go IDLE.
REQ-024 SHALL move GRANT->LOCK when lock[grantee]=1 and request[grantee]=1; in LOCK hold grant regardless of counter, mask and other requests; locked=1.
REQ-025 SHALL leave LOCK when lock[grantee]=0 or request[grantee]=0, rearbitrating from grantee+1 at that edge.
REQ-026 SHALL ignore lock[j] for non-granted j.
REQ-027 SHALL, in IDLE, drive grant=1<<park_index, grant_index=park_index, parked=1 when park_mode=1; grant=0, grant_index=0, parked=0 when park_mode=0.
REQ-028 SHALL drive granted=1 exactly in GRANT/LOCK; parked and granted never both 1.
REQ-029 SHALL, with enable=0, go IDLE at next edge, clear counter, keep last_grantee; enable=0 overrides lock.
REQ-030 SHALL give init_n=0 priority over enable; effect identical to reset but synchronous.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously force IDLE, counter=0, last_grantee=n-1, locked=0, granted=0 and park outputs per REQ-027.
REQ-032 SHALL, after rst_n deasserts mid-burst, begin arbitration on first edge with enable=1, init_n=1, fresh from index 0.

Verification (n=4, w_width=3, park_mode=1, park_index=0)
REQ-033 Reset: rst_n=0 -> grant=0001, grant_index=0, parked=1, granted=0, locked=0 immediately, no clock.
REQ-034 WRR: request=1111, weight={1,1,2,3} for idx{3,2,1,0} -> grant 0001 x3, 0010 x2, 0100 x1, 1000 x1, repeat.
REQ-035 Lock: req0 granted, weight0=1, lock[0]=1 for 5 cycles with request=1111 -> grant=0001, locked=1 throughout; lock[0]=0 -> grant=0010 next cycle.
REQ-036 Mask/drop: request=0110, mask=0010 -> grant=0100 only; drop request[2] -> IDLE, grant=0001, parked=1 next cycle.
REQ-037 Enable/init: mid-burst enable=0 -> IDLE next edge; init_n=0 with enable=1 -> reset values next edge, then search restarts at index 0.
REQ-038 Sole requester: request=1000, weight3=2 -> grant=1000 continuous, granted=1, no gap at reload.
